// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe game controller: move/colour codes, FSM states,
// winning-line table and cell-index helpers. Cells are numbered n = row*3 + col.
package ttt_pkg;

  localparam logic [2:0] MV_UP    = 3'b000;
  localparam logic [2:0] MV_LEFT  = 3'b001;
  localparam logic [2:0] MV_RIGHT = 3'b011;
  localparam logic [2:0] MV_DOWN  = 3'b010;
  localparam logic [2:0] MV_SPACE = 3'b100;
  localparam logic [2:0] MV_NONE  = 3'b111;

  localparam logic [2:0] COL_EMPTY  = 3'b000;
  localparam logic [2:0] COL_CURSOR = 3'b011;
  localparam logic [2:0] COL_P1     = 3'b001;
  localparam logic [2:0] COL_P2     = 3'b010;
  localparam logic [2:0] COL_WIN    = 3'b110;
  localparam logic [2:0] COL_BLINK  = 3'b111;

  typedef logic [1:0] mark_t;
  localparam mark_t MARK_NONE = 2'b00;
  localparam mark_t MARK_P1   = 2'b01;

  typedef enum logic [3:0] {
    INIT, IDLE, ACK, MOVE_OLD, MOVE_NEW, PLACE, CHECK, WIN_PAINT, WAIT_LOW
  } state_e;

  // Board-memory write word; lands on target[7:0]
  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
    logic       pad;
    logic [2:0] colour;
  } tgt_t;

  // Rows 0-2, columns 0-2, main diagonal, anti-diagonal; lower index wins ties
  localparam logic [3:0] LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}};

  function automatic logic [3:0] cell_n(input logic [1:0] col, input logic [1:0] row);
    return {2'b00, row} * 4'd3 + {2'b00, col};
  endfunction

  function automatic logic [1:0] div3(input logic [3:0] n);
    return (n >= 4'd6) ? 2'd2 : (n >= 4'd3) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] mod3(input logic [3:0] n);
    logic [3:0] r;
    r = n - {2'b00, div3(n)} * 4'd3;
    return r[1:0];
  endfunction

  function automatic logic [2:0] disp_col(input mark_t m, input logic cursor);
    if (m == MARK_P1)   return COL_P1;
    if (m != MARK_NONE) return COL_P2;
    return cursor ? COL_CURSOR : COL_EMPTY;
  endfunction

  function automatic tgt_t mk_tgt(input logic [1:0] col, input logic [1:0] row,
                                  input logic [2:0] colour);
    tgt_t t;
    t.col = col; t.row = row; t.pad = 1'b0; t.colour = colour;
    return t;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Key-decoder request/acknowledge handshake plus the VGA board-memory write port.
interface ttt_game_ctrl_if;
  logic [2:0]  move;
  logic        new_button;
  logic        move_ready;
  logic [31:0] target;
  logic        target_save;

  modport master (output move, new_button, input move_ready, target, target_save);
  modport slave  (input move, new_button, output move_ready, target, target_save);
endinterface

// File: rtl/ttt_win_check.sv
// Combinational line/full detector for the board as seen by the player who just moved.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [8:0][1:0] board_i,
  input  logic            player_i,
  output logic            win_o,
  output logic [2:0]      line_o,
  output logic            full_o
);
  mark_t mark;
  assign mark = {player_i, ~player_i};

  always_comb begin
    win_o  = 1'b0;
    line_o = 3'd0;
    full_o = 1'b1;
    for (int c = 0; c < 9; c++)
      if (board_i[c] == MARK_NONE) full_o = 1'b0;
    // Descending scan so the lowest-index winning line is the one reported
    for (int l = 7; l >= 0; l--)
      if (board_i[LINE_TBL[l][0]] == mark && board_i[LINE_TBL[l][1]] == mark &&
          board_i[LINE_TBL[l][2]] == mark) begin
        win_o  = 1'b1;
        line_o = 3'(l);
      end
  end
endmodule

// File: rtl/ttt_game_ctrl.sv
// Two-player tic-tac-toe controller: key handshake, cursor, board, win/draw, repaint.
// Optional macro CURSOR_BLINK_EN adds a blinking cursor repaint while idle.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic           CLK,
  input  logic           CPU_RESETN,
  ttt_game_ctrl_if.slave kb,
  output logic           cur_player,
  output logic           game_over,
  output logic [1:0]     winner
);
  state_e          state_q;
  logic [3:0]      idx_q;
  logic [2:0]      move_q, line_q;
  logic [1:0]      col_q, row_q, col_d, row_d, winner_q;
  logic [8:0][1:0] board_q;
  logic            player_q, over_q, ready_q, save_q;
  tgt_t            tgt_q;
  logic [3:0]      cur_n, new_n, win_n;
  logic            win, full, blink_tick, blink_ph;
  logic [2:0]      win_line;
  mark_t           my_mark;

  assign cur_n   = cell_n(col_q, row_q);
  assign new_n   = cell_n(col_d, row_d);
  assign win_n   = LINE_TBL[line_q][idx_q[1:0]];
  assign my_mark = {player_q, ~player_q};

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    case (move_q)
      MV_UP:    row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
      MV_DOWN:  row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
      MV_LEFT:  col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
      MV_RIGHT: col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
      default: ;
    endcase
  end

  ttt_win_check u_win (
    .board_i (board_q), .player_i (player_q),
    .win_o   (win),     .line_o   (win_line), .full_o (full)
  );

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q;

  assign blink_tick = (blink_cnt_q == BW'(BLINK_CYCLES - 1));
  assign blink_ph   = blink_ph_q;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_tick ? '0 : blink_cnt_q + 1'b1;
      if (state_q == MOVE_OLD || state_q == PLACE) blink_ph_q <= 1'b0;
      else if (blink_tick)                         blink_ph_q <= ~blink_ph_q;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_CYCLES == 0);
  assign blink_tick   = 1'b0;
  assign blink_ph     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= INIT;
      idx_q    <= '0;
      move_q   <= MV_NONE;
      line_q   <= '0;
      col_q    <= 2'd1;
      row_q    <= 2'd1;
      winner_q <= 2'b00;
      board_q  <= '0;
      player_q <= 1'b0;
      over_q   <= 1'b0;
      ready_q  <= 1'b0;
      save_q   <= 1'b0;
      tgt_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      save_q  <= 1'b0;
      case (state_q)
        INIT: begin
          save_q <= 1'b1;
          tgt_q  <= mk_tgt(div3(idx_q), mod3(idx_q),
                           (div3(idx_q) == col_q && mod3(idx_q) == row_q) ? COL_CURSOR : COL_EMPTY);
          idx_q  <= idx_q + 4'd1;
          if (idx_q == 4'd8) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (kb.new_button) begin
            move_q  <= kb.move;
            ready_q <= 1'b1;
            state_q <= ACK;
          end
          if (blink_tick && !over_q) begin
            save_q <= 1'b1;
            tgt_q  <= mk_tgt(col_q, row_q, blink_ph ? disp_col(board_q[cur_n], 1'b1) : COL_BLINK);
          end
        end
        ACK: begin
          if (over_q) begin
            if (move_q == MV_SPACE) begin
              board_q  <= '0;
              player_q <= 1'b0;
              over_q   <= 1'b0;
              winner_q <= 2'b00;
              col_q    <= 2'd1;
              row_q    <= 2'd1;
              idx_q    <= '0;
              state_q  <= INIT;
            end else state_q <= WAIT_LOW;
          end else begin
            case (move_q)
              MV_UP, MV_LEFT, MV_RIGHT, MV_DOWN: state_q <= MOVE_OLD;
              MV_SPACE:                          state_q <= PLACE;
              default:                           state_q <= WAIT_LOW;
            endcase
          end
        end
        MOVE_OLD: begin
          save_q  <= 1'b1;
          tgt_q   <= mk_tgt(col_q, row_q, disp_col(board_q[cur_n], 1'b0));
          state_q <= MOVE_NEW;
        end
        MOVE_NEW: begin
          col_q   <= col_d;
          row_q   <= row_d;
          save_q  <= 1'b1;
          tgt_q   <= mk_tgt(col_d, row_d, disp_col(board_q[new_n], 1'b1));
          state_q <= WAIT_LOW;
        end
        PLACE: begin
          if (board_q[cur_n] != MARK_NONE) state_q <= WAIT_LOW;
          else begin
            board_q[cur_n] <= my_mark;
            save_q         <= 1'b1;
            tgt_q          <= mk_tgt(col_q, row_q, disp_col(my_mark, 1'b0));
            state_q        <= CHECK;
          end
        end
        CHECK: begin
          if (win) begin
            winner_q <= my_mark;
            over_q   <= 1'b1;
            line_q   <= win_line;
            idx_q    <= '0;
            state_q  <= WIN_PAINT;
          end else if (full) begin
            winner_q <= 2'b11;
            over_q   <= 1'b1;
            state_q  <= WAIT_LOW;
          end else begin
            player_q <= ~player_q;
            state_q  <= WAIT_LOW;
          end
        end
        WIN_PAINT: begin
          save_q <= 1'b1;
          tgt_q  <= mk_tgt(mod3(win_n), div3(win_n), COL_WIN);
          idx_q  <= idx_q + 4'd1;
          if (idx_q == 4'd2) begin
            idx_q   <= '0;
            state_q <= WAIT_LOW;
          end
        end
        WAIT_LOW: if (!kb.new_button) state_q <= IDLE;
        default:  state_q <= INIT;
      endcase
    end
  end

  assign kb.move_ready  = ready_q;
  assign kb.target_save = save_q;
  assign kb.target      = {24'd0, tgt_q};
  assign cur_player     = player_q;
  assign game_over      = over_q;
  assign winner         = winner_q;
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: a board-level game model predicts every write,
// acknowledge and status value; a negedge monitor checks writes as they appear.
module tb_ttt_game_ctrl;
  logic       CLK = 1'b0;
  logic       CPU_RESETN = 1'b0;
  logic       cur_player, game_over;
  logic [1:0] winner;

  always #5 CLK = ~CLK;

  ttt_game_ctrl_if kb();

  ttt_game_ctrl dut (
    .CLK (CLK), .CPU_RESETN (CPU_RESETN), .kb (kb),
    .cur_player (cur_player), .game_over (game_over), .winner (winner)
  );

  int checks = 0, errors = 0;
  int acks_seen = 0, acks_exp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  // Game model: bd[col][row] holds 0 empty, 1 P1, 2 P2
  int bd[3][3];
  int mc, mr, mp, mover, mwin;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void push_w(input int c, input int r, input int colr);
    exp_q.push_back(8'(c * 64 + r * 16 + colr));
  endfunction

  function automatic int disp(input int c, input int r, input bit cur);
    if (bd[c][r] != 0) return bd[c][r];
    return cur ? 3 : 0;
  endfunction

  function automatic void line_cell(input int l, input int k, output int c, output int r);
    if (l < 3)       begin c = k;     r = l; end
    else if (l < 6)  begin c = l - 3; r = k; end
    else if (l == 6) begin c = k;     r = k; end
    else             begin c = 2 - k; r = k; end
  endfunction

  function automatic void model_init();
    foreach (bd[c, r]) bd[c][r] = 0;
    mc = 1; mr = 1; mp = 0; mover = 0; mwin = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) push_w(c, r, (c == 1 && r == 1) ? 3 : 0);
  endfunction

  function automatic void model_req(input int code);
    int dc, dr, c, r, filled, found;
    acks_exp++;
    if (mover != 0) begin
      if (code == 4) model_init();
      return;
    end
    dc = 0; dr = 0;
    case (code)
      0: dr = -1;
      1: dc = -1;
      3: dc = 1;
      2: dr = 1;
      default: ;
    endcase
    if (code < 4) begin
      push_w(mc, mr, disp(mc, mr, 0));
      mc = (mc + dc + 3) % 3;
      mr = (mr + dr + 3) % 3;
      push_w(mc, mr, disp(mc, mr, 1));
    end else if (code == 4 && bd[mc][mr] == 0) begin
      bd[mc][mr] = mp + 1;
      push_w(mc, mr, mp + 1);
      found = -1;
      for (int l = 0; l < 8 && found < 0; l++) begin
        int hits = 0;
        for (int k = 0; k < 3; k++) begin
          line_cell(l, k, c, r);
          if (bd[c][r] == mp + 1) hits++;
        end
        if (hits == 3) found = l;
      end
      filled = 0;
      foreach (bd[i, j]) if (bd[i][j] != 0) filled++;
      if (found >= 0) begin
        mwin = mp + 1; mover = 1;
        for (int k = 0; k < 3; k++) begin
          line_cell(found, k, c, r);
          push_w(c, r, 6);
        end
      end else if (filled == 9) begin
        mwin = 3; mover = 1;
      end else mp ^= 1;
    end
  endfunction

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge CLK) begin
    if (CPU_RESETN) begin
      if (kb.move_ready) acks_seen++;
      if (kb.target_save) begin
        if (exp_q.size() == 0) chk("unexpected_write", kb.target, 32'hFFFF_FFFF);
        else begin
          exp_w = exp_q.pop_front();
          chk("write_target", kb.target, {24'd0, exp_w});
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_acks"}, 32'(acks_seen), 32'(acks_exp));
    chk({tag, "_cur_player"}, {31'd0, cur_player}, 32'(mp));
    chk({tag, "_game_over"}, {31'd0, game_over}, 32'(mover));
    chk({tag, "_winner"}, {30'd0, winner}, 32'(mwin));
  endtask

  task automatic req(input int code, input int hold, input bit settle);
    int n;
    model_req(code);
    @(negedge CLK);
    kb.move = 3'(code);
    kb.new_button = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!kb.move_ready && n < 30);
    chk("ack_seen", {31'd0, kb.move_ready}, 32'd1);
    repeat (hold) @(negedge CLK);
    kb.new_button = 1'b0;
    kb.move = 3'($urandom);
    if (settle) begin
      repeat (14) @(negedge CLK);
      check_idle("req");
    end
  endtask

  task automatic goto_cell(input int c, input int r);
    while (mc != c) req(3, $urandom_range(0, 3), 1'b1);
    while (mr != r) req(2, $urandom_range(0, 3), 1'b1);
  endtask

  task automatic place(input int c, input int r);
    goto_cell(c, r);
    req(4, $urandom_range(0, 3), 1'b1);
  endtask

  task automatic do_reset();
    CPU_RESETN = 1'b0;
    kb.new_button = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    chk("rst_target", kb.target, 32'd0);
    chk("rst_target_save", {31'd0, kb.target_save}, 32'd0);
    chk("rst_move_ready", {31'd0, kb.move_ready}, 32'd0);
    chk("rst_status", {28'd0, cur_player, game_over, winner}, 32'd0);
    model_init();
    CPU_RESETN = 1'b1;
    @(negedge CLK);
    chk("init_first_cycle", {31'd0, kb.target_save}, 32'd1);
    repeat (12) @(negedge CLK);
    check_idle("init");
  endtask

  initial begin
    int n, r, code;
    kb.move = 3'd0;
    kb.new_button = 1'b0;
    do_reset();

    // Held request acknowledged once; then wrap right from column 2
    req(0, 5, 1'b1);
    req(3, 0, 1'b1);
    req(3, 1, 1'b1);

    // P1 wins row 0, with an occupied-cell space in between
    place(0, 0);
    req(4, 1, 1'b1);
    place(0, 1);
    place(1, 0);
    place(1, 1);
    place(2, 0);
    req(0, 0, 1'b1);
    req(4, 0, 1'b1);

    // Draw: P1 (0,0)(2,0)(0,1)(1,2)(2,2), P2 (1,0)(1,1)(2,1)(0,2)
    place(0, 0); place(1, 0); place(2, 0); place(1, 1); place(0, 1);
    place(2, 1); place(1, 2); place(0, 2); place(2, 2);
    req(4, 0, 1'b1);

    repeat (80) begin
      r = $urandom_range(0, 7);
      code = (r < 4) ? r : (r < 6) ? 4 : (r == 6) ? $urandom_range(5, 7) : $urandom_range(0, 3);
      req(code, $urandom_range(0, 3), 1'b1);
    end

    // Reset in the middle of the winning-line repaint
    do_reset();
    place(1, 1); place(0, 0); place(1, 0); place(2, 0);
    goto_cell(1, 2);
    req(4, 0, 1'b0);
    n = 0;
    while (!game_over && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("win_game_over", {31'd0, game_over}, 32'd1);
    @(negedge CLK);
    chk("win_paint_active", {31'd0, kb.target_save}, 32'd1);
    #2 CPU_RESETN = 1'b0;
    #1;
    chk("async_rst_save", {31'd0, kb.target_save}, 32'd0);
    chk("async_rst_over", {30'd0, game_over, winner[1]}, 32'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
